// File: rtl/mux4_arbiter_if.sv
// Request/grant bundle between four requesting units and the 4:1 mux arbiter.
`default_nettype none

interface mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;

  modport master (output req, input grant, input sel, input busy);
  modport slave  (input req, output grant, output sel, output busy);
endinterface

`default_nettype wire

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner arbitration for a shared 4:1 mux select,
// with a hold limit that forces rotation only while others are waiting.
`default_nettype none

module mux4_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux4_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    owner;
  logic [CW-1:0] cnt;

  logic [3:0]    cand;
  logic          found;
  logic [1:0]    win;
  logic [1:0]    idx;

  // The owner is excluded from the search so release/rotation always moves on.
  always_comb begin
    cand  = (state == OWN) ? (bus.req & ~(4'b0001 << owner)) : bus.req;
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      cnt       <= '0;
      bus.grant <= 4'b0000;
      bus.sel   <= 2'd0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= OWN;
            owner     <= win;
            ptr       <= win + 2'd1;
            cnt       <= CNT_ONE;
            bus.grant <= 4'b0001 << win;
            bus.sel   <= win;
            bus.busy  <= 1'b1;
          end
        end
        OWN: begin
          if (bus.req[owner] && cnt < HOLD_LIMIT) begin
            cnt <= cnt + CNT_ONE;
          end else if (found) begin
            owner     <= win;
            ptr       <= win + 2'd1;
            cnt       <= CNT_ONE;
            bus.grant <= 4'b0001 << win;
            bus.sel   <= win;
            bus.busy  <= 1'b1;
          end else if (!bus.req[owner]) begin
            // sel deliberately keeps the last owner while idle.
            state     <= IDLE;
            bus.grant <= 4'b0000;
            bus.busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter using three instances (MAX_HOLD 8, 4, 1).
`default_nettype none

module tb_mux4_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux4_arbiter_if if8 ();
  mux4_arbiter_if if4 ();
  mux4_arbiter_if if1 ();

  mux4_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  mux4_arbiter #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  mux4_arbiter #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    if8.req = 4'b0000;
    if4.req = 4'b0000;
    if1.req = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    if8.req = 4'b1111;
    if4.req = 4'b1111;
    if1.req = 4'b1111;
    repeat (3) @(negedge clk);
    checks++;
    if (if8.grant !== 4'b0000 || if8.sel !== 2'd0 || if8.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold8 grant=%b sel=%0d busy=%b expected 0000/0/0", if8.grant, if8.sel, if8.busy);
    end
    checks++;
    if (if4.grant !== 4'b0000 || if1.grant !== 4'b0000 || if4.busy !== 1'b0 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_others grant4=%b grant1=%b expected 0000", if4.grant, if1.grant);
    end
    if8.req = 4'b0000;
    if4.req = 4'b0000;
    if1.req = 4'b0000;
    rst_n   = 1'b1;
    if8.req = 4'b0100;
    @(negedge clk);
    checks++;
    if (if8.grant !== 4'b0100 || if8.sel !== 2'd2) begin
      errors++;
      $display("FAIL reset_pre_pulse grant=%b sel=%0d expected 0100/2", if8.grant, if8.sel);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (if8.grant !== 4'b0000 || if8.sel !== 2'd0 || if8.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async grant=%b sel=%0d busy=%b expected 0000/0/0", if8.grant, if8.sel, if8.busy);
    end
    @(negedge clk);
    // From ptr=0, 1010 must pick source 1, not source 3.
    rst_n   = 1'b1;
    if8.req = 4'b1010;
    @(negedge clk);
    checks++;
    if (if8.grant !== 4'b0010 || if8.sel !== 2'd1) begin
      errors++;
      $display("FAIL reset_restart grant=%b sel=%0d expected 0010/1", if8.grant, if8.sel);
    end
  endtask

  task automatic test_single();
    do_reset();
    if8.req = 4'b0100;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      checks++;
      if (if8.grant !== 4'b0100 || if8.sel !== 2'd2 || if8.busy !== 1'b1) begin
        errors++;
        $display("FAIL single_hold cyc=%0d grant=%b sel=%0d busy=%b expected 0100/2/1", n, if8.grant, if8.sel, if8.busy);
      end
    end
    if8.req = 4'b0000;
    for (int n = 4; n <= 5; n++) begin
      @(negedge clk);
      checks++;
      if (if8.grant !== 4'b0000 || if8.sel !== 2'd2 || if8.busy !== 1'b0) begin
        errors++;
        $display("FAIL single_idle cyc=%0d grant=%b sel=%0d busy=%b expected 0000/2/0", n, if8.grant, if8.sel, if8.busy);
      end
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_owner;
    logic [3:0] exp_grant;
    do_reset();
    if8.req = 4'b1111;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      exp_owner = 2'(((n - 1) / 8) % 4);
      exp_grant = 4'b0001 << exp_owner;
      checks++;
      if (if8.grant !== exp_grant || if8.sel !== exp_owner) begin
        errors++;
        $display("FAIL rotation cyc=%0d grant=%b sel=%0d expected %b/%0d", n, if8.grant, if8.sel, exp_grant, exp_owner);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    if8.req = 4'b0011;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      checks++;
      if (if8.grant !== 4'b0001) begin
        errors++;
        $display("FAIL handoff_first cyc=%0d grant=%b expected 0001", n, if8.grant);
      end
    end
    if8.req = 4'b0010;
    for (int n = 3; n <= 4; n++) begin
      @(negedge clk);
      checks++;
      if (if8.grant !== 4'b0010 || if8.sel !== 2'd1 || if8.busy !== 1'b1) begin
        errors++;
        $display("FAIL handoff_next cyc=%0d grant=%b sel=%0d expected 0010/1", n, if8.grant, if8.sel);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    if4.req = 4'b1000;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks++;
      if (if4.grant !== 4'b1000 || if4.sel !== 2'd3) begin
        errors++;
        $display("FAIL saturate cyc=%0d grant=%b sel=%0d expected 1000/3", n, if4.grant, if4.sel);
      end
    end
    if4.req = 4'b1001;
    @(negedge clk);
    checks++;
    if (if4.grant !== 4'b0001 || if4.sel !== 2'd0) begin
      errors++;
      $display("FAIL saturate_rotate grant=%b sel=%0d expected 0001/0", if4.grant, if4.sel);
    end
  endtask

  task automatic test_max_hold_one();
    logic [3:0] exp_grant;
    do_reset();
    if1.req = 4'b0101;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_grant = (n % 2 == 1) ? 4'b0001 : 4'b0100;
      checks++;
      if (if1.grant !== exp_grant || if1.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_one cyc=%0d grant=%b busy=%b expected %b/1", n, if1.grant, if1.busy, exp_grant);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_rotation();
    test_handoff();
    test_saturation();
    test_max_hold_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
